// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, requester indices and arbiter state type
package cnn_pkg;

    localparam int MEM_ADDR_SIZE = 20;
    localparam int DATA_SIZE     = 16;

    localparam int REQ_CTRL = 0;
    localparam int REQ_POOL = 1;
    localparam int REQ_CONV = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder starting after the last grant
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk (last_grant+1 .. last_grant+NUM_REQ) mod NUM_REQ; the previous winner is checked last.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin owner of the single DMA port with completion/timeout return
module dma_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int MEM_ADDR_SIZE  = cnn_pkg::MEM_ADDR_SIZE,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      reqValid,
    input  logic [NUM_REQ-1:0][MEM_ADDR_SIZE-1:0]   reqAddr,
    input  logic [NUM_REQ-1:0]                      reqRW,
    output logic [NUM_REQ-1:0]                      reqGrant,
    output logic [NUM_REQ-1:0]                      reqDone,
    output logic [NUM_REQ-1:0]                      reqErr,
    output logic                                    dmaEnable,
    output logic [MEM_ADDR_SIZE-1:0]                address,
    output logic                                    dmaRWSignal,
    input  logic                                    opDone
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    cnn_pkg::arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]         req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0]         req_done_q, req_done_d;
    logic [NUM_REQ-1:0]         req_err_q, req_err_d;
    logic                       dma_enable_q, dma_enable_d;
    logic [MEM_ADDR_SIZE-1:0]   address_q, address_d;
    logic                       dma_rw_q, dma_rw_d;
    logic [CNT_W-1:0]           timer_q, timer_d;

    logic [NUM_REQ-1:0]         pick;
    logic [IDX_W-1:0]           pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_valid  (reqValid),
        .last_grant (last_grant_q),
        .pick       (pick),
        .pick_idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_grant_d  = req_grant_q;
        req_done_d   = '0;
        req_err_d    = '0;
        dma_enable_d = dma_enable_q;
        address_d    = address_q;
        dma_rw_d     = dma_rw_q;
        timer_d      = timer_q;

        case (state_q)
            cnn_pkg::IDLE: begin
                if (|reqValid) begin
                    address_d    = reqAddr[pick_idx];
                    dma_rw_d     = reqRW[pick_idx];
                    req_grant_d  = pick;
                    last_grant_d = pick_idx;
                    dma_enable_d = 1'b1;
                    timer_d      = '0;
                    state_d      = cnn_pkg::BUSY;
                end
            end

            cnn_pkg::BUSY: begin
                if (timer_q != CNT_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                // A completion on the timeout edge still counts as a clean finish.
                if (opDone) begin
                    dma_enable_d = 1'b0;
                    req_done_d   = req_grant_q;
                    state_d      = cnn_pkg::DONE;
                end else if (timer_q == CNT_LAST) begin
                    dma_enable_d = 1'b0;
                    req_done_d   = req_grant_q;
                    req_err_d    = req_grant_q;
                    state_d      = cnn_pkg::DONE;
                end
            end

            cnn_pkg::DONE: begin
                req_grant_d = '0;
                state_d     = cnn_pkg::IDLE;
            end

            default: begin
                req_grant_d  = '0;
                dma_enable_d = 1'b0;
                state_d      = cnn_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= cnn_pkg::IDLE;
            last_grant_q <= IDX_LAST;
            req_grant_q  <= '0;
            req_done_q   <= '0;
            req_err_q    <= '0;
            dma_enable_q <= 1'b0;
            address_q    <= '0;
            dma_rw_q     <= 1'b1;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_grant_q  <= req_grant_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            dma_enable_q <= dma_enable_d;
            address_q    <= address_d;
            dma_rw_q     <= dma_rw_d;
            timer_q      <= timer_d;
        end
    end

    assign reqGrant    = req_grant_q;
    assign reqDone     = req_done_q;
    assign reqErr      = req_err_q;
    assign dmaEnable   = dma_enable_q;
    assign address     = address_q;
    assign dmaRWSignal = dma_rw_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - scoreboard bench for dma_arbiter grants, completions, timeouts and reset
module tb_dma_arbiter;

    localparam int N  = 3;
    localparam int AW = 20;
    localparam int TO = 8;

    typedef struct {
        logic [N-1:0]  grant;
        logic [AW-1:0] addr;
        logic          rw;
    } gexp_t;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] err;
        int           len;
    } cexp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         reqValid;
    logic [N-1:0][AW-1:0] reqAddr;
    logic [N-1:0]         reqRW;
    logic [N-1:0]         reqGrant;
    logic [N-1:0]         reqDone;
    logic [N-1:0]         reqErr;
    logic                 dmaEnable;
    logic [AW-1:0]        address;
    logic                 dmaRWSignal;
    logic                 opDone;

    int    checks = 0;
    int    errors = 0;
    int    exp_last;
    gexp_t gq[$];
    cexp_t cq[$];

    dma_arbiter #(
        .NUM_REQ        (N),
        .MEM_ADDR_SIZE  (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqAddr     (reqAddr),
        .reqRW       (reqRW),
        .reqGrant    (reqGrant),
        .reqDone     (reqDone),
        .reqErr      (reqErr),
        .dmaEnable   (dmaEnable),
        .address     (address),
        .dmaRWSignal (dmaRWSignal),
        .opDone      (opDone)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input logic [N-1:0] v, input int last);
        int idx;
        for (int i = 1; i <= N; i++) begin
            idx = (last + i) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Monitor: pops expectations when the DUT starts or finishes a transfer.
    gexp_t        mg;
    cexp_t        mc;
    logic         prev_en   = 1'b0;
    logic [N-1:0] prev_done = '0;
    int           busy_cnt  = 0;
    logic [AW-1:0] cur_addr = '0;
    logic          cur_rw   = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (dmaEnable && !prev_en) begin
                if (gq.size() == 0) begin
                    check_eq("grant_unexpected", 32'(reqGrant), 32'(0));
                end else begin
                    mg = gq.pop_front();
                    check_eq("grant", 32'(reqGrant), 32'(mg.grant));
                    check_eq("addr", 32'(address), 32'(mg.addr));
                    check_eq("rw", 32'(dmaRWSignal), 32'(mg.rw));
                    cur_addr = mg.addr;
                    cur_rw   = mg.rw;
                end
                busy_cnt = 0;
            end
            if (dmaEnable) begin
                busy_cnt++;
                check_eq("addr_hold", 32'(address), 32'(cur_addr));
                check_eq("rw_hold", 32'(dmaRWSignal), 32'(cur_rw));
            end
            if (reqDone != '0 || reqErr != '0) begin
                if (cq.size() == 0) begin
                    check_eq("done_unexpected", 32'(reqDone), 32'(0));
                end else begin
                    mc = cq.pop_front();
                    check_eq("done_vec", 32'(reqDone), 32'(mc.done));
                    check_eq("err_vec", 32'(reqErr), 32'(mc.err));
                    check_eq("busy_len", 32'(busy_cnt), 32'(mc.len));
                    check_eq("grant_at_done", 32'(reqGrant), 32'(mc.done));
                    check_eq("en_at_done", 32'(dmaEnable), 32'(0));
                end
            end
            if (prev_done != '0) begin
                check_eq("post_done_grant", 32'(reqGrant), 32'(0));
                check_eq("post_done_pulse", 32'(reqDone), 32'(0));
            end
            prev_en   = dmaEnable;
            prev_done = reqDone;
        end else begin
            prev_en   = 1'b0;
            prev_done = '0;
        end
    end

    task automatic wait_grant();
        int n = 0;
        while (!dmaEnable && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!dmaEnable) check_eq("grant_wait", 32'(0), 32'(1));
    endtask

    // delay = cycles from grant to opDone sample; 0 means never complete (timeout expected).
    task automatic xfer(input int delay, input bit drop);
        int         g;
        int         n;
        logic [1:0] gi;
        gexp_t      ge;
        cexp_t      ce;
        g = rr_next(reqValid, exp_last);
        if (g < 0) begin
            check_eq("model_pick", 32'(0), 32'(1));
            return;
        end
        gi       = 2'(g);
        exp_last = g;
        ge.grant = 3'b001 << g;
        ge.addr  = reqAddr[gi];
        ge.rw    = reqRW[gi];
        gq.push_back(ge);
        ce.done  = 3'b001 << g;
        ce.err   = (delay == 0) ? ce.done : 3'b000;
        ce.len   = (delay == 0) ? TO : delay;
        cq.push_back(ce);
        wait_grant();
        if (delay > 0) begin
            repeat (delay - 1) @(negedge clk);
            opDone = 1'b1;
            @(negedge clk);
            opDone = 1'b0;
        end
        n = 0;
        while (reqDone == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (reqDone == '0) check_eq("done_wait", 32'(0), 32'(1));
        if (drop) reqValid[gi] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        gexp_t rg;
        reset    = 1'b1;
        reqValid = '0;
        reqAddr  = '0;
        reqRW    = '0;
        opDone   = 1'b0;
        exp_last = N - 1;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(reqGrant), 32'(0));
        check_eq("rst_done", 32'(reqDone), 32'(0));
        check_eq("rst_err", 32'(reqErr), 32'(0));
        check_eq("rst_en", 32'(dmaEnable), 32'(0));
        check_eq("rst_addr", 32'(address), 32'(0));
        check_eq("rst_rw", 32'(dmaRWSignal), 32'(1));
        #2 reset = 1'b0;
        @(negedge clk);

        // Single read from requester 0
        reqAddr[0] = 20'h00010;
        reqRW      = 3'b001;
        reqValid   = 3'b001;
        xfer(5, 1'b1);

        // All requesters held valid: strict rotation
        reqAddr[0] = 20'h0A000;
        reqAddr[1] = 20'h0B004;
        reqAddr[2] = 20'h0C008;
        reqRW      = 3'b010;
        reqValid   = 3'b111;
        for (int i = 0; i < 6; i++) xfer(2, 1'b0);
        reqValid = '0;

        // Granted requester changes address/direction and drops valid mid-transfer
        reqAddr[1] = 20'h00400;
        reqRW[1]   = 1'b0;
        reqValid   = 3'b010;
        fork
            xfer(4, 1'b0);
            begin
                repeat (3) @(negedge clk);
                reqAddr[1]  = 20'h00800;
                reqRW[1]    = 1'b1;
                reqValid[1] = 1'b0;
            end
        join
        reqValid = '0;

        // Timeout on requester 2, then requester 0 served normally
        reqAddr[2] = 20'h3FFFF;
        reqAddr[0] = 20'h12345;
        reqRW      = 3'b101;
        reqValid   = 3'b101;
        xfer(0, 1'b1);
        xfer(3, 1'b1);

        // Completion one edge before, and exactly on, the timeout edge
        reqAddr[1] = 20'h0F0F0;
        reqValid   = 3'b010;
        xfer(7, 1'b1);
        reqValid   = 3'b010;
        xfer(TO, 1'b1);

        // opDone outside BUSY is ignored
        opDone = 1'b1;
        repeat (3) @(negedge clk);
        opDone = 1'b0;
        check_eq("idle_opdone_en", 32'(dmaEnable), 32'(0));
        check_eq("idle_opdone_done", 32'(reqDone), 32'(0));

        // Reset three cycles into a transfer
        reqAddr[1] = 20'h0ABCD;
        reqValid   = 3'b010;
        rg.grant   = 3'b010;
        rg.addr    = reqAddr[1];
        rg.rw      = reqRW[1];
        check_eq("model_reset_pick", 32'(rr_next(reqValid, exp_last)), 32'(1));
        gq.push_back(rg);
        wait_grant();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_en", 32'(dmaEnable), 32'(0));
        check_eq("arst_grant", 32'(reqGrant), 32'(0));
        check_eq("arst_done", 32'(reqDone), 32'(0));
        check_eq("arst_err", 32'(reqErr), 32'(0));
        check_eq("arst_addr", 32'(address), 32'(0));
        check_eq("arst_rw", 32'(dmaRWSignal), 32'(1));
        exp_last   = N - 1;
        reqAddr[0] = 20'h00ACE;
        reqAddr[1] = 20'h00BEE;
        reqRW      = 3'b011;
        reqValid   = 3'b111;
        @(negedge clk);
        #2 reset = 1'b0;
        xfer(1, 1'b0);
        xfer(1, 1'b0);
        reqValid = '0;
        repeat (4) @(negedge clk);

        check_eq("sb_grant_left", 32'(gq.size()), 32'(0));
        check_eq("sb_done_left", 32'(cq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
